// File: rtl/opcode_fetch.sv
// 6809 instruction fetch front end: walks prefix/opcode/EA/operand bytes from memory
// and hands each complete instruction bundle to execute over a valid/ready handshake.
module opcode_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        cpu_clk,
    input  logic        cpu_reset_n,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_data_i,
    input  logic        mem_ack,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [7:0]  opcode,
    output logic [7:0]  postbyte0,
    output logic        page2_valid,
    output logic        page3_valid,
    output logic [7:0]  eapostbyte,
    output logic [15:0] operand,
    output logic [2:0]  ins_len,
    output logic [15:0] ins_pc
);

    localparam logic [2:0] S_OP   = 3'd0;
    localparam logic [2:0] S_PB0  = 3'd1;
    localparam logic [2:0] S_EA   = 3'd2;
    localparam logic [2:0] S_HI   = 3'd3;
    localparam logic [2:0] S_LO   = 3'd4;
    localparam logic [2:0] S_HOLD = 3'd5;

    logic [2:0]  state;
    logic [2:0]  state_next;
    logic        running;
    logic        accept;
    logic        is_prefix;
    logic [15:0] pc;
    logic [2:0]  cls;
    logic [1:0]  ea_n;

    // Returns {indexed, operand byte count}.
    function automatic logic [2:0] classify(input logic [7:0] e, input logic prefixed);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = e[7:4];
        lo = e[3:0];
        classify = 3'b000;
        if (prefixed) begin
            if (hi inside {4'hA, 4'hE}) classify = 3'b100;
            else if (hi inside {4'h9, 4'hD}) classify = 3'b001;
            else if (hi inside {4'h2, 4'h7, 4'h8, 4'hB, 4'hC, 4'hF}) classify = 3'b010;
        end else begin
            if (hi inside {4'h6, 4'hA, 4'hE} || e inside {[8'h30:8'h33]}) classify = 3'b100;
            else if (e == 8'hCD) classify = 3'b000;
            else if (hi inside {4'h7, 4'hB, 4'hF} ||
                     e inside {8'h16, 8'h17, 8'h83, 8'h8C, 8'h8E, 8'hC3, 8'hCC, 8'hCE})
                classify = 3'b010;
            else if (hi inside {4'h0, 4'h2, 4'h8, 4'h9, 4'hC, 4'hD} ||
                     e inside {8'h1A, 8'h1C, 8'h1E, 8'h1F, [8'h34:8'h37]})
                classify = 3'b001;
            else if (lo == 4'h0 && hi == 4'h1) classify = 3'b000;
        end
    endfunction

    function automatic logic [1:0] ea_offset(input logic [7:0] pb);
        ea_offset = 2'd0;
        if (pb[7]) begin
            if (pb[3:0] == 4'h8 || pb[3:0] == 4'hC) ea_offset = 2'd1;
            else if (pb[3:0] == 4'h9 || pb[3:0] == 4'hD || pb[4:0] == 5'h1F) ea_offset = 2'd2;
        end
    endfunction

    function automatic logic [2:0] operand_state(input logic [1:0] n);
        if (n == 2'd2) operand_state = S_HI;
        else if (n == 2'd1) operand_state = S_LO;
        else operand_state = S_HOLD;
    endfunction

    // Request drops combinationally in a redirect cycle so the concurrent ack is discarded.
    assign mem_rd    = running && (state != S_HOLD) && !redirect;
    assign accept    = mem_rd && mem_ack;
    assign mem_addr  = pc;
    assign ins_valid = (state == S_HOLD);
    assign is_prefix = (mem_data_i == 8'h10) || (mem_data_i == 8'h11);
    assign cls       = classify(mem_data_i, state == S_PB0);
    assign ea_n      = ea_offset(mem_data_i);

    always_comb begin
        state_next = state;
        if (redirect) begin
            state_next = S_OP;
        end else if (state == S_HOLD) begin
            if (ins_ready) state_next = S_OP;
        end else if (accept) begin
            case (state)
                S_OP, S_PB0: begin
                    if (state == S_OP && is_prefix) state_next = S_PB0;
                    else if (cls[2]) state_next = S_EA;
                    else state_next = operand_state(cls[1:0]);
                end
                S_EA:    state_next = operand_state(ea_n);
                S_HI:    state_next = S_LO;
                S_LO:    state_next = S_HOLD;
                default: state_next = S_OP;
            endcase
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            state   <= S_OP;
            running <= 1'b0;
            pc      <= RESET_PC;
        end else begin
            state   <= state_next;
            running <= 1'b1;
            if (redirect) pc <= redirect_pc;
            else if (accept) pc <= pc + 16'd1;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            opcode      <= 8'h00;
            postbyte0   <= 8'h00;
            page2_valid <= 1'b0;
            page3_valid <= 1'b0;
            eapostbyte  <= 8'h00;
            operand     <= 16'h0000;
            ins_len     <= 3'd0;
            ins_pc      <= 16'h0000;
        end else if (redirect) begin
            opcode      <= 8'h00;
            postbyte0   <= 8'h00;
            page2_valid <= 1'b0;
            page3_valid <= 1'b0;
            eapostbyte  <= 8'h00;
            operand     <= 16'h0000;
            ins_len     <= 3'd0;
            ins_pc      <= 16'h0000;
        end else if (accept) begin
            case (state)
                S_OP: begin
                    opcode      <= mem_data_i;
                    postbyte0   <= 8'h00;
                    page2_valid <= (mem_data_i == 8'h10);
                    page3_valid <= (mem_data_i == 8'h11);
                    eapostbyte  <= 8'h00;
                    operand     <= 16'h0000;
                    ins_len     <= 3'd1;
                    ins_pc      <= pc;
                end
                S_PB0: begin
                    postbyte0 <= mem_data_i;
                    ins_len   <= ins_len + 3'd1;
                end
                S_EA: begin
                    eapostbyte <= mem_data_i;
                    ins_len    <= ins_len + 3'd1;
                end
                S_HI: begin
                    operand[15:8] <= mem_data_i;
                    ins_len       <= ins_len + 3'd1;
                end
                S_LO: begin
                    operand[7:0] <= mem_data_i;
                    ins_len      <= ins_len + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
